// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C SERDES step interface between two requesters.
// Grants whole transactions, closes abandoned ones with STOP, and aborts hung steps.
module i2c_bus_arbiter #(
  parameter int TIMEOUT_CYC = 200000,
  parameter int CNT_W       = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r0_req,
  input  logic       r1_req,
  output logic       r0_gnt,
  output logic       r1_gnt,
  input  logic [1:0] r0_step,
  input  logic [1:0] r1_step,
  input  logic [7:0] r0_tx,
  input  logic [7:0] r1_tx,
  input  logic       r0_valid,
  input  logic       r1_valid,
  output logic       r0_done,
  output logic       r1_done,
  output logic [7:0] r0_rx,
  output logic [7:0] r1_rx,
  output logic       r0_err,
  output logic       r1_err,
  output logic [1:0] drv_next_step,
  output logic [7:0] drv_tx_byte,
  output logic       drv_start,
  input  logic [7:0] drv_rx_byte,
  input  logic       drv_ready,
  output logic       drv_abort
);

  // state     | meaning
  // IDLE      | no owner; arbitrate pending requests
  // OWNED     | owner holds the bus; waiting for a step strobe or release
  // WAIT      | step launched to SERDES; waiting for drv_ready, watchdog running
  // AUTO_STOP | owner released mid-transaction; STOP issued, waiting for drv_ready
  // ABORT     | watchdog expired; one-cycle SERDES abort and owner error
  typedef enum logic [2:0] {
    IDLE,
    OWNED,
    WAIT,
    AUTO_STOP,
    ABORT
  } state_t;

  localparam logic [1:0]       STEP_STOP = 2'b00;
  localparam logic [1:0]       STEP_READ = 2'b11;
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] WD_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] WD_ZERO   = '0;

  state_t           state, state_d;
  logic             last_owner, last_owner_d;
  logic             stop_pending, stop_pending_d;
  logic [CNT_W-1:0] wd, wd_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [7:0]       rx0_q, rx0_d;
  logic [7:0]       rx1_q, rx1_d;
  logic [1:0]       step_q, step_d;
  logic [7:0]       tx_q, tx_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;

  logic             own_req;
  logic             own_valid;
  logic [1:0]       own_step;
  logic [7:0]       own_tx;
  logic             wd_expired;
  logic             go_abort;

  // last_owner doubles as the current owner while the bus is held
  assign own_req    = last_owner ? r1_req   : r0_req;
  assign own_valid  = last_owner ? r1_valid : r0_valid;
  assign own_step   = last_owner ? r1_step  : r0_step;
  assign own_tx     = last_owner ? r1_tx    : r0_tx;
  assign wd_expired = (wd == WD_LAST);

  always_comb begin
    state_d        = state;
    last_owner_d   = last_owner;
    stop_pending_d = stop_pending;
    wd_d           = wd;
    gnt_d          = gnt_q;
    done_d         = 2'b00;
    err_d          = 2'b00;
    rx0_d          = rx0_q;
    rx1_d          = rx1_q;
    step_d         = step_q;
    tx_d           = tx_q;
    start_d        = 1'b0;
    abort_d        = 1'b0;
    go_abort       = 1'b0;

    case (state)
      IDLE: begin
        if (r0_req && (!r1_req || last_owner)) begin
          gnt_d        = 2'b01;
          last_owner_d = 1'b0;
          state_d      = OWNED;
        end else if (r1_req) begin
          gnt_d        = 2'b10;
          last_owner_d = 1'b1;
          state_d      = OWNED;
        end
      end

      OWNED: begin
        if (!own_req) begin
          gnt_d = 2'b00;
          if (stop_pending) begin
            step_d  = STEP_STOP;
            start_d = 1'b1;
            wd_d    = WD_ZERO;
            state_d = AUTO_STOP;
          end else begin
            state_d = IDLE;
          end
        end else if (own_valid) begin
          step_d         = own_step;
          tx_d           = own_tx;
          start_d        = 1'b1;
          stop_pending_d = (own_step != STEP_STOP);
          wd_d           = WD_ZERO;
          state_d        = WAIT;
        end
      end

      WAIT: begin
        // drv_ready takes priority over a coincident watchdog expiry
        if (drv_ready) begin
          done_d = last_owner ? 2'b10 : 2'b01;
          if (step_q == STEP_READ) begin
            if (last_owner) rx1_d = drv_rx_byte;
            else            rx0_d = drv_rx_byte;
          end
          wd_d    = WD_ZERO;
          state_d = OWNED;
        end else if (wd_expired) begin
          go_abort = 1'b1;
        end else begin
          wd_d = wd + WD_ONE;
        end
      end

      AUTO_STOP: begin
        if (drv_ready) begin
          stop_pending_d = 1'b0;
          wd_d           = WD_ZERO;
          state_d        = IDLE;
        end else if (wd_expired) begin
          go_abort = 1'b1;
        end else begin
          wd_d = wd + WD_ONE;
        end
      end

      ABORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    if (go_abort) begin
      state_d        = ABORT;
      abort_d        = 1'b1;
      err_d          = last_owner ? 2'b10 : 2'b01;
      gnt_d          = 2'b00;
      stop_pending_d = 1'b0;
      wd_d           = WD_ZERO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_owner   <= 1'b1;
      stop_pending <= 1'b0;
      wd           <= WD_ZERO;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      rx0_q        <= 8'h00;
      rx1_q        <= 8'h00;
      step_q       <= 2'b00;
      tx_q         <= 8'h00;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state        <= state_d;
      last_owner   <= last_owner_d;
      stop_pending <= stop_pending_d;
      wd           <= wd_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rx0_q        <= rx0_d;
      rx1_q        <= rx1_d;
      step_q       <= step_d;
      tx_q         <= tx_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
    end
  end

  assign r0_gnt        = gnt_q[0];
  assign r1_gnt        = gnt_q[1];
  assign r0_done       = done_q[0];
  assign r1_done       = done_q[1];
  assign r0_err        = err_q[0];
  assign r1_err        = err_q[1];
  assign r0_rx         = rx0_q;
  assign r1_rx         = rx1_q;
  assign drv_next_step = step_q;
  assign drv_tx_byte   = tx_q;
  assign drv_start     = start_q;
  assign drv_abort     = abort_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: the bench plays the SERDES and both requesters,
// and a scoreboard queue holds the expected owner/rx of every done pulse.
module tb_i2c_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic       r0_req, r1_req;
  logic       r0_gnt, r1_gnt;
  logic [1:0] r0_step, r1_step;
  logic [7:0] r0_tx, r1_tx;
  logic       r0_valid, r1_valid;
  logic       r0_done, r1_done;
  logic [7:0] r0_rx, r1_rx;
  logic       r0_err, r1_err;
  logic [1:0] drv_next_step;
  logic [7:0] drv_tx_byte;
  logic       drv_start;
  logic [7:0] drv_rx_byte;
  logic       drv_ready;
  logic       drv_abort;

  i2c_bus_arbiter #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r1_req(r1_req),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
    .r0_step(r0_step), .r1_step(r1_step),
    .r0_tx(r0_tx), .r1_tx(r1_tx),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_done(r0_done), .r1_done(r1_done),
    .r0_rx(r0_rx), .r1_rx(r1_rx),
    .r0_err(r0_err), .r1_err(r1_err),
    .drv_next_step(drv_next_step), .drv_tx_byte(drv_tx_byte),
    .drv_start(drv_start), .drv_rx_byte(drv_rx_byte),
    .drv_ready(drv_ready), .drv_abort(drv_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [7:0] rx;
  } sb_t;

  sb_t  sb[$];
  int   checks = 0;
  int   failures = 0;
  int   start_cnt = 0;
  int   abort_cnt = 0;
  int   done0_cnt = 0;
  int   done1_cnt = 0;
  logic [7:0] exp_rx0 = 8'h00;
  logic [7:0] exp_rx1 = 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input logic id, input logic [7:0] rx);
    sb_t e;
    check("done_expected", {63'd0, sb.size() != 0}, 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("done_owner", {63'd0, id}, {63'd0, e.id});
      check("done_rx", {56'd0, rx}, {56'd0, e.rx});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    exp_rx0 = 8'h00;
    exp_rx1 = 8'h00;
    sb.delete();
    check("reset_outputs",
          {30'd0, r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, drv_start, drv_abort,
           drv_next_step, drv_tx_byte, r0_rx, r1_rx}, 64'd0);
    rst_n = 1'b1;
  endtask

  // owner issues one step; the bench answers as the SERDES after lat cycles
  task automatic do_step(input logic id, input logic [1:0] st, input logic [7:0] tx,
                         input logic [7:0] rb, input int lat);
    if (id) begin r1_step = st; r1_tx = tx; r1_valid = 1'b1; end
    else    begin r0_step = st; r0_tx = tx; r0_valid = 1'b1; end
    tick();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    check("launch_start", {63'd0, drv_start}, 64'd1);
    check("launch_step", {62'd0, drv_next_step}, {62'd0, st});
    check("launch_tx", {56'd0, drv_tx_byte}, {56'd0, tx});
    repeat (lat) tick();
    check("start_one_cycle", {63'd0, drv_start}, 64'd0);
    check("hold_tx", {56'd0, drv_tx_byte}, {56'd0, tx});
    if (st == 2'b11) begin
      if (id) exp_rx1 = rb;
      else    exp_rx0 = rb;
    end
    sb.push_back({id, id ? exp_rx1 : exp_rx0});
    drv_rx_byte = rb;
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    drv_rx_byte = 8'h00;
  endtask

  task automatic wait_gnt(input string tag, input logic [1:0] exp);
    int n = 0;
    while (!(r0_gnt | r1_gnt) && n < 4) begin
      tick();
      n++;
    end
    check(tag, {62'd0, r1_gnt, r0_gnt}, {62'd0, exp});
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int   s0, d0, d1, ab, abort_at;
    logic err_seen, gnt0_seen, gnt1_seen;
    logic [1:0] exp_g;

    rst_n = 1'b0; r0_req = 0; r1_req = 0; r0_step = 0; r1_step = 0;
    r0_tx = 0; r1_tx = 0; r0_valid = 0; r1_valid = 0; drv_rx_byte = 0; drv_ready = 0;

    fork
      forever begin
        @(negedge clk);
        if (drv_start) start_cnt++;
        if (drv_abort) abort_cnt++;
        if (r0_gnt | r1_gnt) check("gnt_exclusive", {63'd0, r0_gnt & r1_gnt}, 64'd0);
        if (r0_done) begin done0_cnt++; pop_check(1'b0, r0_rx); end
        if (r1_done) begin done1_cnt++; pop_check(1'b1, r1_rx); end
      end
    join_none

    do_reset();

    // r0 alone: full transaction ending in its own STOP
    r0_req = 1'b1;
    tick();
    check("r0_gnt_latency", {62'd0, r1_gnt, r0_gnt}, 64'd1);
    d0 = done0_cnt;
    do_step(1'b0, 2'b01, 8'h90, 8'hA5, 2);
    do_step(1'b0, 2'b10, 8'h00, 8'h5A, 1);
    do_step(1'b0, 2'b11, 8'h00, 8'h1A, 3);
    do_step(1'b0, 2'b00, 8'h00, 8'h77, 1);
    tick();
    check("r0_done_count", done0_cnt - d0, 4);
    check("r0_rx_held", {56'd0, r0_rx}, 64'h1A);
    s0 = start_cnt;
    r0_req = 1'b0;
    tick();
    check("r0_release_gnt", {62'd0, r1_gnt, r0_gnt}, 64'd0);
    repeat (4) tick();
    check("no_auto_stop", start_cnt - s0, 0);

    // simultaneous requests: strict alternation r0, r1, r0, r1
    do_reset();
    r0_req = 1'b1;
    r1_req = 1'b1;
    exp_g = 2'b01;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("rr_grant", exp_g);
      do_step(exp_g[1], 2'b00, 8'h00, 8'h00, 1);
      if (exp_g[1]) r1_req = 1'b0; else r0_req = 1'b0;
      tick();
      check("rr_idle_gap", {62'd0, r1_gnt, r0_gnt}, 64'd0);
      if (exp_g[1]) r1_req = 1'b1; else r0_req = 1'b1;
      exp_g = ~exp_g;
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    repeat (3) tick();

    // r1 abandons after START+write: arbiter closes with STOP
    r1_req = 1'b1;
    wait_gnt("r1_grant", 2'b10);
    do_step(1'b1, 2'b01, 8'h91, 8'h66, 2);
    tick();
    d1 = done1_cnt;
    r1_req = 1'b0;
    tick();
    check("auto_stop_start", {63'd0, drv_start}, 64'd1);
    check("auto_stop_code", {62'd0, drv_next_step}, 64'd0);
    check("auto_stop_gnt", {62'd0, r1_gnt, r0_gnt}, 64'd0);
    tick();
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    r0_req = 1'b1;
    tick();
    check("auto_stop_to_idle", {62'd0, r1_gnt, r0_gnt}, 64'd1);
    check("auto_stop_no_done", done1_cnt - d1, 0);
    check("auto_stop_rx1", {56'd0, r1_rx}, 64'h00);
    r0_req = 1'b0;
    repeat (2) tick();

    // watchdog expiry on r0 with r1 waiting
    r0_req = 1'b1;
    wait_gnt("wd_r0_grant", 2'b01);
    r1_req = 1'b1;
    ab = abort_cnt;
    r0_step = 2'b10; r0_tx = 8'h3C; r0_valid = 1'b1;
    tick();
    r0_valid = 1'b0;
    check("wd_start", {63'd0, drv_start}, 64'd1);
    abort_at = -1; err_seen = 0; gnt0_seen = 1; gnt1_seen = 1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (drv_abort) begin
        abort_at = k; err_seen = r0_err; gnt0_seen = r0_gnt; gnt1_seen = r1_gnt;
        break;
      end
    end
    check("wd_abort_cycle", abort_at, 16);
    check("wd_err", {63'd0, err_seen}, 64'd1);
    check("wd_gnt_drop", {62'd0, gnt1_seen, gnt0_seen}, 64'd0);
    r0_req = 1'b0;
    tick();
    check("wd_abort_pulse", {61'd0, drv_abort, r0_err, r1_err}, 64'd0);
    wait_gnt("wd_r1_after_abort", 2'b10);

    // ready coinciding with expiry completes the step
    r1_step = 2'b11; r1_valid = 1'b1;
    tick();
    r1_valid = 1'b0;
    check("wd2_start", {63'd0, drv_start}, 64'd1);
    repeat (15) tick();
    exp_rx1 = 8'h5C;
    sb.push_back({1'b1, 8'h5C});
    drv_rx_byte = 8'h5C;
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    drv_rx_byte = 8'h00;
    check("wd2_no_abort", {62'd0, drv_abort, r1_err}, 64'd0);
    check("wd2_done", {63'd0, r1_done}, 64'd1);
    repeat (3) tick();
    check("wd2_abort_count", abort_cnt - ab, 1);
    do_step(1'b1, 2'b00, 8'h00, 8'h00, 1);
    r1_req = 1'b0;
    repeat (2) tick();

    // non-owner strobes and spurious ready while r0 owns
    r0_req = 1'b1;
    wait_gnt("ni_grant", 2'b01);
    s0 = start_cnt; d0 = done0_cnt; d1 = done1_cnt;
    r1_step = 2'b01; r1_tx = 8'hAA; r1_valid = 1'b1;
    tick();
    r1_valid = 1'b0;
    tick();
    drv_rx_byte = 8'hEE;
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    drv_rx_byte = 8'h00;
    repeat (2) tick();
    check("ni_no_start", start_cnt - s0, 0);
    check("ni_no_done", (done0_cnt - d0) + (done1_cnt - d1), 0);
    check("ni_r1_rx", {56'd0, r1_rx}, {56'd0, exp_rx1});
    check("ni_r0_rx", {56'd0, r0_rx}, {56'd0, exp_rx0});
    do_step(1'b0, 2'b11, 8'h00, 8'h33, 1);
    do_step(1'b0, 2'b00, 8'h00, 8'h00, 1);
    tick();
    check("ni_r0_read", {56'd0, r0_rx}, 64'h33);

    // asynchronous reset while a step is outstanding
    r0_step = 2'b10; r0_tx = 8'h42; r0_valid = 1'b1;
    tick();
    r0_valid = 1'b0;
    check("ar_start", {63'd0, drv_start}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_clear",
          {54'd0, r0_gnt, r1_gnt, drv_start, r0_done, r1_done, drv_abort, drv_next_step, r0_rx},
          64'd0);
    sb.delete();
    exp_rx0 = 8'h00;
    exp_rx1 = 8'h00;
    r1_req = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("ar_tie_to_r0", {62'd0, r1_gnt, r0_gnt}, 64'd1);
    r0_req = 1'b0;
    r1_req = 1'b0;
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
